// File: rtl/wb_queue_if.sv
// Bundles the wb_queue signals: the producer handshake, the registered regfile write port,
// the two ID-stage bypass lookups and the occupancy. The producer uses master; the queue uses slave.
interface wb_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wreg;
  logic [ADDR_W-1:0] in_wd;
  logic [DATA_W-1:0] in_wdata;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [ADDR_W-1:0] byp1_addr;
  logic              byp1_hit;
  logic [DATA_W-1:0] byp1_data;
  logic [ADDR_W-1:0] byp2_addr;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp2_data;

  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_wreg, in_wd, in_wdata, byp1_addr, byp2_addr,
    input  in_ready, we, waddr, wdata, byp1_hit, byp1_data, byp2_hit, byp2_data, count
  );

  modport slave (
    input  in_valid, in_wreg, in_wd, in_wdata, byp1_addr, byp2_addr,
    output in_ready, we, waddr, wdata, byp1_hit, byp1_data, byp2_hit, byp2_data, count
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue feeding the regfile write port, with two bypass lookups for ID operands.
// Optional macro WB_QUEUE_COALESCE_EN merges a write into the youngest queued entry with the same register.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
) (
  input logic        clk,
  input logic        rst,
  wb_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              in_ready;
  logic              xfer;
  logic              enq;
  logic              coalesce;
  logic              alloc;
  logic              pop;

  logic              byp1_hit;
  logic [DATA_W-1:0] byp1_data;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp2_data;
  logic [PTR_W-1:0]  idx;

  // A pop in the same cycle never frees a slot for the incoming request.
  assign in_ready = rst && (count_q != CNT_W'(DEPTH));
  assign xfer     = bus.in_valid && in_ready;
  assign enq      = xfer && bus.in_wreg && (bus.in_wd != '0);
  assign pop      = (count_q != '0);

`ifdef WB_QUEUE_COALESCE_EN
  logic [PTR_W-1:0] young_idx;
  assign young_idx = wr_ptr - PTR_W'(1);
  // With a single entry the youngest is also the head leaving this cycle, so it cannot be merged into.
  assign coalesce  = enq && (count_q > CNT_W'(1)) && (mem_addr[young_idx] == bus.in_wd);
`else
  assign coalesce  = 1'b0;
`endif

  assign alloc = enq && !coalesce;

  // Storage carries no reset; occupancy and pointers decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_addr[wr_ptr] <= bus.in_wd;
      mem_data[wr_ptr] <= bus.in_wdata;
    end
`ifdef WB_QUEUE_COALESCE_EN
    if (coalesce) begin
      mem_data[young_idx] <= bus.in_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (pop) begin
        we_q    <= 1'b1;
        waddr_q <= mem_addr[rd_ptr];
        wdata_q <= mem_data[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end else begin
        we_q    <= 1'b0;
      end

      if (alloc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      case ({alloc, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk oldest to youngest so a younger match overwrites an older one; the output stage is older than any entry.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    idx       = '0;

    if (we_q && (waddr_q == bus.byp1_addr)) begin
      byp1_hit  = 1'b1;
      byp1_data = wdata_q;
    end
    if (we_q && (waddr_q == bus.byp2_addr)) begin
      byp2_hit  = 1'b1;
      byp2_data = wdata_q;
    end

    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PTR_W'(1) - PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (mem_addr[idx] == bus.byp1_addr)) begin
        byp1_hit  = 1'b1;
        byp1_data = mem_data[idx];
      end
      if ((CNT_W'(k) < count_q) && (mem_addr[idx] == bus.byp2_addr)) begin
        byp2_hit  = 1'b1;
        byp2_data = mem_data[idx];
      end
    end

    if (bus.byp1_addr == '0) begin
      byp1_hit  = 1'b0;
      byp1_data = '0;
    end
    if (bus.byp2_addr == '0) begin
      byp2_hit  = 1'b0;
      byp2_data = '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.byp1_hit  = byp1_hit;
  assign bus.byp1_data = byp1_data;
  assign bus.byp2_hit  = byp2_hit;
  assign bus.byp2_data = byp2_data;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// Directed and random stimulus for wb_queue, checked every cycle against a
// queue-based reference model plus constant expectations at key points.
module tb_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 3;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic rst;
  wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  ent_t              mq[$];
  bit                m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                model_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Youngest queued value first, then the value sitting in the output stage.
  function automatic logic [DATA_W:0] refBypass(input logic [ADDR_W-1:0] a);
    if (a == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_we && (m_waddr == a)) return {1'b1, m_wdata};
    return '0;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input bit wr, input logic [ADDR_W-1:0] wd,
                               input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2);
    logic [DATA_W:0] e1;
    logic [DATA_W:0] e2;
    bit              xfer;
    ent_t            e;
    rst           = r;
    bus.in_valid  = v;
    bus.in_wreg   = wr;
    bus.in_wd     = wd;
    bus.in_wdata  = d;
    bus.byp1_addr = a1;
    bus.byp2_addr = a2;
    @(negedge clk);
    checkOutput("in_ready", DATA_W'(bus.in_ready), DATA_W'(r && (mq.size() != DEPTH)));
    if (model_valid) begin
      e1 = refBypass(a1);
      e2 = refBypass(a2);
      checkOutput("count", DATA_W'(bus.count), DATA_W'(mq.size()));
      checkOutput("we", DATA_W'(bus.we), DATA_W'(m_we));
      checkOutput("waddr", DATA_W'(bus.waddr), DATA_W'(m_waddr));
      checkOutput("wdata", bus.wdata, m_wdata);
      checkOutput("byp1_hit", DATA_W'(bus.byp1_hit), DATA_W'(e1[DATA_W]));
      checkOutput("byp1_data", bus.byp1_data, e1[DATA_W-1:0]);
      checkOutput("byp2_hit", DATA_W'(bus.byp2_hit), DATA_W'(e2[DATA_W]));
      checkOutput("byp2_data", bus.byp2_data, e2[DATA_W-1:0]);
    end
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_we        = 0;
      m_waddr     = '0;
      m_wdata     = '0;
      model_valid = 1;
    end else begin
      xfer = v && (mq.size() != DEPTH);
`ifdef WB_QUEUE_COALESCE_EN
      if (xfer && wr && wd != '0 && mq.size() >= 2 && mq[mq.size()-1].a == wd) begin
        mq[mq.size()-1].d = d;
        xfer = 0;
      end
`endif
      if (mq.size() > 0) begin
        e       = mq.pop_front();
        m_we    = 1;
        m_waddr = e.a;
        m_wdata = e.d;
      end else begin
        m_we = 0;
      end
      if (xfer && wr && wd != '0) mq.push_back('{a: wd, d: d});
    end
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_wreg   = 1'b0;
    bus.in_wd     = '0;
    bus.in_wdata  = '0;
    bus.byp1_addr = '0;
    bus.byp2_addr = '0;

    $display("[TB] reset");
    applyStimulus(0, 1, 1, 5'd2, 32'h55, 5'd2, 5'd0);
    applyStimulus(0, 1, 1, 5'd2, 32'h55, 5'd2, 5'd0);
    checkOutput("rst_we", DATA_W'(bus.we), 32'd0);
    checkOutput("rst_count", DATA_W'(bus.count), 32'd0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("rel_ready", DATA_W'(bus.in_ready), 32'd1);

    $display("[TB] single write");
    applyStimulus(1, 1, 1, 5'd3, 32'h1234, 5'd3, 5'd0);
    checkOutput("single_byp_hit", DATA_W'(bus.byp1_hit), 32'd1);
    checkOutput("single_byp_data", bus.byp1_data, 32'h1234);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd3, 5'd0);
    checkOutput("single_we", DATA_W'(bus.we), 32'd1);
    checkOutput("single_waddr", DATA_W'(bus.waddr), 32'd3);
    checkOutput("single_wdata", bus.wdata, 32'h1234);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("single_count", DATA_W'(bus.count), 32'd0);

    $display("[TB] stream");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 1, 1, ADDR_W'(i), DATA_W'(i * 32'h11), 5'd0, 5'd0);
      if (i >= 2) checkOutput("stream_waddr", DATA_W'(bus.waddr), DATA_W'(i - 1));
    end
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("stream_last_waddr", DATA_W'(bus.waddr), 32'd6);
    checkOutput("stream_last_wdata", bus.wdata, 32'h66);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    $display("[TB] filter");
    applyStimulus(1, 1, 0, 5'd4, 32'h77, 5'd4, 5'd0);
    checkOutput("filter_wreg_count", DATA_W'(bus.count), 32'd0);
    applyStimulus(1, 1, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    checkOutput("filter_r0_count", DATA_W'(bus.count), 32'd0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("filter_we", DATA_W'(bus.we), 32'd0);

    $display("[TB] bypass priority");
    applyStimulus(1, 1, 1, 5'd5, 32'hA, 5'd0, 5'd5);
    applyStimulus(1, 1, 1, 5'd5, 32'hB, 5'd0, 5'd5);
    checkOutput("prio_byp2_data", bus.byp2_data, 32'hB);
    checkOutput("prio_first_wdata", bus.wdata, 32'hA);
    checkOutput("prio_r0_hit", DATA_W'(bus.byp1_hit), 32'd0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd5);
    checkOutput("prio_second_wdata", bus.wdata, 32'hB);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    $display("[TB] reset mid-drain");
    applyStimulus(1, 1, 1, 5'd9, 32'h99, 5'd9, 5'd0);
    applyStimulus(0, 1, 1, 5'd10, 32'hAA, 5'd9, 5'd10);
    checkOutput("middrain_count", DATA_W'(bus.count), 32'd0);
    checkOutput("middrain_we", DATA_W'(bus.we), 32'd0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd9, 5'd10);
    checkOutput("middrain_no_write", DATA_W'(bus.we), 32'd0);

    $display("[TB] random");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom_range(0, 7) != 0),
                    ADDR_W'($urandom_range(0, 7)), $urandom,
                    ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
